multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Main control FSM of the MIPS multi-cycle datapath, directly upstream of the ALU decoder.
- Decodes the 6-bit opcode from the instruction register and sequences fetch/decode/execute/memory/writeback steps.
- Drives every datapath enable and mux select, including the 2-bit ALUOp consumed by the ALU decoder.
- Moore machine: all outputs are a pure function of the current state.

Parameters:
- (none; state encoding fixed as listed under Behaviour)

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Op  input  6  opcode field Instr[31:26] from instruction register
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  register file write address: 0=rt, 1=rd
- MemtoReg  output  1  register file write data: 0=ALUOut, 1=Data
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A: 0=PC, 1=register A
- ALUSrcB  output  2  ALU B: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- ALUOp  output  2  to ALU decoder: 00=add, 01=subtract, 10=use Funct
- PCSrc  output  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
- PCWrite  output  1  unconditional PC load
- Branch  output  1  conditional PC load (PC enable = PCWrite | (Branch & Zero), formed outside)
- State  output  4  current state code, for debug/verification

Behaviour:
- Single clock domain; state register updates on posedge CLK.
- Reset=1 at a clock edge forces state FETCH(0), regardless of the current state, including mid-instruction. Reset has priority over all transitions.
- While in reset, outputs are the FETCH values, since outputs are decoded from state.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
- States, outputs and transitions (outputs not listed are 0):
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by Op: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP; any other Op->FETCH.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: LW->MEMRD, SW->MEMWR; otherwise FETCH.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1. Next: FETCH.
- Codes 12-15 are unreachable. If entered, all outputs are 0 and next state is FETCH.
- Op is sampled only in DECODE and MEMADR. It is held stable by the IR, since IRWrite=0 outside FETCH.
- Cycles per instruction, FETCH to FETCH: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
- At most one of IRWrite/MemWrite/RegWrite is asserted in any state.

Test Plan:
- Reset held 2 cycles then released, Op=100011 (LW) -> State sequence 0,1,2,3,4,0. In state 4: RegWrite=1, MemtoReg=1. In state 0: IRWrite=1, PCWrite=1, ALUSrcB=01.
- Op=000000 (RTYPE) -> States 0,1,6,7,0. State 6: ALUOp=10, ALUSrcA=1, ALUSrcB=00. State 7: RegDst=1, RegWrite=1.
- Op=000100 (BEQ), then Op=000010 (J) -> BEQ visits 0,1,8,0 with ALUOp=01, PCSrc=01, Branch=1, PCWrite=0. J visits 0,1,11,0 with PCSrc=10, PCWrite=1.
- Op=101011 (SW), then Op=001000 (ADDI) -> SW visits 0,1,2,5,0 with IorD=1, MemWrite=1 in state 5. ADDI visits 0,1,9,10,0 with ALUSrcB=10 in 9 and RegWrite=1, RegDst=0 in 10.
- Op=111111 (illegal) -> States 0,1,0. No RegWrite or MemWrite asserted at any point.
- Reset asserted in state 3 (LW mid-flight) -> next edge State=0, MemWrite=RegWrite=0. Normal LW sequence resumes after Reset deasserts.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the MIPS multi-cycle datapath.
// Sequences fetch/decode/execute/memory/writeback steps from the IR opcode
// and drives every datapath enable and mux select as a Moore machine.
module multicycle_main_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Op,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] r_state;
  logic [3:0] w_next;

  // State register; reset overrides any transition, even mid-instruction.
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_LW)      w_next = S_MEMRD;
        else if (Op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Output decode from current state only; unused codes leave everything at 0.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed test-plan sequences with literal
// expectations, then random opcode/reset stimulus against an instruction-level model.
module tb_multicycle_main_control;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Op;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCWrite, Branch;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  multicycle_main_control dut (
    .CLK(CLK), .Reset(Reset), .Op(Op),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .Branch(Branch), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcwrite, branch;
  } outs_t;

  // Instruction-level model: cycles per instruction and the state at each step.
  function automatic int cpi(input logic [5:0] op);
    case (op)
      LW:            return 5;
      SW, RT, ADDI:  return 4;
      BEQ, JMP:      return 3;
      default:       return 2;
    endcase
  endfunction

  function automatic logic [3:0] state_at(input logic [5:0] op, input int pos);
    if (pos == 0) return 4'd0;
    if (pos == 1) return 4'd1;
    case (op)
      LW:      return (pos == 2) ? 4'd2 : ((pos == 3) ? 4'd3 : 4'd4);
      SW:      return (pos == 2) ? 4'd2 : 4'd5;
      RT:      return (pos == 2) ? 4'd6 : 4'd7;
      BEQ:     return 4'd8;
      ADDI:    return (pos == 2) ? 4'd9 : 4'd10;
      JMP:     return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic outs_t outs_for(input logic [3:0] s);
    outs_t o;
    o = '0;
    case (s)
      4'd0:  begin o.alusrcb = 2'b01; o.irwrite = 1'b1; o.pcwrite = 1'b1; end
      4'd1:  o.alusrcb = 2'b11;
      4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      4'd3:  o.iord = 1'b1;
      4'd4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      4'd5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      4'd6:  begin o.alusrca = 1'b1; o.aluop = 2'b10; end
      4'd7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      4'd8:  begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch = 1'b1; end
      4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      4'd10: o.regwrite = 1'b1;
      4'd11: begin o.pcsrc = 2'b10; o.pcwrite = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  int m_pos = 0;

  // Model advance: position within the current instruction, wrapping at its CPI.
  always @(posedge CLK) begin
    if (Reset)                       m_pos <= 0;
    else if (m_pos + 1 >= cpi(Op))   m_pos <= 0;
    else                             m_pos <= m_pos + 1;
  end

  outs_t dut_outs;
  assign dut_outs = '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                      ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    logic [3:0] es;
    outs_t      eo;
    es = state_at(Op, m_pos);
    eo = outs_for(es);
    checks++;
    if (State !== es) begin
      errors++;
      $display("FAIL model_state t=%0t got %0d exp %0d (Op=%b)", $time, State, es, Op);
    end
    checks++;
    if (dut_outs !== eo) begin
      errors++;
      $display("FAIL model_outs t=%0t state=%0d got %b exp %b", $time, State, dut_outs, eo);
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Walk one instruction from FETCH, checking literal states and test-plan outputs.
  task automatic run_path(input logic [5:0] op, input int n, input logic [3:0] p [6]);
    Op = op;
    for (int i = 0; i < n; i++) begin
      lit("path_state", State, p[i]);
      case (p[i])
        4'd0:  begin lit("fetch_irwrite", IRWrite, 1); lit("fetch_pcwrite", PCWrite, 1);
                     lit("fetch_alusrcb", ALUSrcB, 1); end
        4'd4:  begin lit("memwb_regwrite", RegWrite, 1); lit("memwb_memtoreg", MemtoReg, 1); end
        4'd5:  begin lit("memwr_iord", IorD, 1); lit("memwr_memwrite", MemWrite, 1); end
        4'd6:  begin lit("exec_aluop", ALUOp, 2); lit("exec_alusrca", ALUSrcA, 1);
                     lit("exec_alusrcb", ALUSrcB, 0); end
        4'd7:  begin lit("aluwb_regdst", RegDst, 1); lit("aluwb_regwrite", RegWrite, 1); end
        4'd8:  begin lit("br_aluop", ALUOp, 1); lit("br_pcsrc", PCSrc, 1);
                     lit("br_branch", Branch, 1); lit("br_pcwrite", PCWrite, 0); end
        4'd9:  lit("addiex_alusrcb", ALUSrcB, 2);
        4'd10: begin lit("addiwb_regwrite", RegWrite, 1); lit("addiwb_regdst", RegDst, 0); end
        4'd11: begin lit("jump_pcsrc", PCSrc, 2); lit("jump_pcwrite", PCWrite, 1); end
        default: ;
      endcase
      if (op == 6'b111111) begin
        lit("illegal_regwrite", RegWrite, 0);
        lit("illegal_memwrite", MemWrite, 0);
      end
      @(negedge CLK);
    end
    lit("path_return_fetch", State, 0);
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    Reset = 1'b1;
    Op = LW;
    repeat (2) @(negedge CLK);
    lit("reset_state", State, 0);
    lit("reset_irwrite", IRWrite, 1);
    Reset = 1'b0;

    run_path(LW,  5, '{0, 1, 2, 3, 4, 0});
    run_path(RT,  4, '{0, 1, 6, 7, 0, 0});
    run_path(BEQ, 3, '{0, 1, 8, 0, 0, 0});
    run_path(JMP, 3, '{0, 1, 11, 0, 0, 0});
    run_path(SW,  4, '{0, 1, 2, 5, 0, 0});
    run_path(ADDI, 4, '{0, 1, 9, 10, 0, 0});
    run_path(6'b111111, 2, '{0, 1, 0, 0, 0, 0});

    // Reset mid-flight in MEMRD, then a clean LW.
    Op = LW;
    repeat (3) @(negedge CLK);
    lit("midflight_state3", State, 3);
    Reset = 1'b1;
    @(negedge CLK);
    lit("midreset_state", State, 0);
    lit("midreset_memwrite", MemWrite, 0);
    lit("midreset_regwrite", RegWrite, 0);
    Reset = 1'b0;
    run_path(LW, 5, '{0, 1, 2, 3, 4, 0});

    // Random opcodes and sporadic resets; Op only changes while in FETCH.
    for (int c = 0; c < 3000; c++) begin
      if (m_pos == 0) begin
        if ($urandom_range(0, 4) == 0) Op = 6'($urandom);
        else                          Op = ops[$urandom_range(0, 5)];
      end
      Reset = ($urandom_range(0, 39) == 0);
      @(negedge CLK);
    end
    Reset = 1'b0;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
